yt_system_pio_key: RTL and testbench
====================================

YT_SYSTEM_PIO_KEY -- requirements
Module: yt_system_pio_key

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning number of input bits.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 50000, meaning the number of stable clk cycles required to accept a new level; 0 means bypass.
REQ-003 SHALL have parameter EDGE_MODE, default 1, meaning 0 = rising, 1 = falling, 2 = any edge.
REQ-004 SHALL have parameter RESET_LEVEL, default all-ones of WIDTH, meaning the assumed idle input level after reset (keys are active-low).
REQ-005 SHALL have port clk, input, 1 bit: the system clock; all logic is rising-edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port address, input, 3 bits: Avalon-MM word address.
REQ-008 SHALL have port chipselect, input, 1 bit: Avalon-MM slave select.
REQ-009 SHALL have port write_n, input, 1 bit: Avalon-MM active-low write strobe.
REQ-010 SHALL have port writedata, input, 32 bits: Avalon-MM write data.
REQ-011 SHALL have port in_port, input, WIDTH bits: asynchronous external key/switch inputs.
REQ-012 SHALL have port readdata, output, 32 bits: Avalon-MM read data with read latency 1.
REQ-013 SHALL have port irq, output, 1 bit: active-high level interrupt.

Function
REQ-014 SHALL pass in_port through a two-flop synchronizer per bit before any other use.
REQ-015 SHALL keep, per bit, a debounce counter and a stable level; the counter clears whenever the synchronized bit equals the stable level.
REQ-016 SHALL increment a bit's counter while the synchronized bit differs from its stable level; when the counter reaches DEBOUNCE_CNT-1, the stable level takes the synchronized value and the counter clears in the same cycle.
REQ-017 SHALL, when DEBOUNCE_CNT = 0, load the stable level directly from the synchronizer output every cycle.
REQ-018 SHALL size the counter as clog2(DEBOUNCE_CNT+1) bits; the counter never wraps because it clears at terminal count.
REQ-019 SHALL detect edges by comparing the stable level with its one-cycle-delayed copy, qualified by EDGE_MODE.
REQ-020 SHALL set edge_capture[i] on a detected edge of bit i; the bit holds until cleared.
REQ-021 SHALL use the following register map (bits above WIDTH read as 0):
- 0: data, read-only, stable levels; writes ignored.
- 2: irq_mask, read/write, WIDTH bits.
- 3: edge_capture, read; writing clears every bit where writedata[i] = 1.
- 1 and 4..7: read 0; writes ignored.
REQ-022 SHALL define a write as chipselect=1 and write_n=0, taking effect at that clk edge.
REQ-023 SHALL give set priority over clear when an edge and a write-1-to-clear hit the same bit in the same cycle; the bit remains 1.
REQ-024 SHALL register readdata every clk from the current address regardless of chipselect, giving read latency 1.
REQ-025 SHALL drive irq combinationally as the OR-reduction of (edge_capture & irq_mask).
REQ-026 SHALL add a total latency of 2 (sync) + DEBOUNCE_CNT + 1 cycles from an in_port change to the edge_capture set.

Reset
REQ-027 SHALL asynchronously, on reset_n = 0, set the synchronizer flops, stable level and delayed copy to RESET_LEVEL.
REQ-028 SHALL, on reset_n = 0, set the counters, irq_mask, edge_capture and readdata to 0; irq is therefore 0.
REQ-029 SHALL generate no spurious edge on reset release when in_port equals RESET_LEVEL.
REQ-030 SHALL discard any debounce in progress when reset is asserted mid-count; no capture results.

Verification
REQ-031 SHALL cover falling-edge capture: DEBOUNCE_CNT=4, EDGE_MODE=1; drive in_port 4'hF->4'hE and hold -> edge_capture reads 4'h1 at cycle 2+4+1 after the change, and data reads 4'hE.
REQ-032 SHALL cover glitch rejection: DEBOUNCE_CNT=4; pulse in_port[0] low for 3 cycles -> data stays 4'hF and edge_capture stays 0.
REQ-033 SHALL cover interrupt masking: with edge_capture=4'h1 and irq_mask=0, irq=0; write 4'h1 to address 2 -> irq=1 the next cycle; write 4'h1 to address 3 -> irq=0 and edge_capture=0.
REQ-034 SHALL cover set/clear collision: a write-1-to-clear of bit 0 in the same cycle as a new bit-0 edge -> edge_capture[0]=1.
REQ-035 SHALL cover read latency and unmapped addresses: address=2 with irq_mask=4'h5 -> readdata=32'h5 one cycle later; address=6 -> readdata=0.
REQ-036 SHALL cover reset mid-debounce: assert reset_n=0 at count 2 -> all registers return to reset values with no capture and irq=0.

Source files
------------

// File: rtl/yt_system_pio_key.sv
// yt_system_pio_key: debounced key/switch PIO with edge capture and IRQ.
// Ports: clk, reset_n (async low), Avalon-MM slave (address, chipselect,
//   write_n, writedata, readdata with read latency 1), in_port (async keys),
//   irq (level, OR of edge_capture & irq_mask).
module yt_system_pio_key #(
    parameter int               WIDTH        = 4,
    parameter int               DEBOUNCE_CNT = 50000,
    parameter int               EDGE_MODE    = 1,
    parameter logic [WIDTH-1:0] RESET_LEVEL  = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // Counter width never collapses to zero, even in bypass mode.
    localparam int CW = (DEBOUNCE_CNT > 0) ? $clog2(DEBOUNCE_CNT + 1) : 1;
    localparam logic [CW-1:0] TERM =
        (DEBOUNCE_CNT > 0) ? CW'(DEBOUNCE_CNT - 1) : '0;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] clr;
    logic             wr;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign unused_wdata = &{1'b0, writedata[31:WIDTH]};

    // Two-flop synchronizer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= RESET_LEVEL;
            sync2 <= RESET_LEVEL;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    // Debounce: a new level is accepted only after it has differed from
    // the stable level for DEBOUNCE_CNT consecutive cycles.
    generate
        if (DEBOUNCE_CNT == 0) begin : g_bypass
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stable <= RESET_LEVEL;
                    for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
                end else begin
                    stable <= sync2;
                    for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
                end
            end
        end else begin : g_debounce
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stable <= RESET_LEVEL;
                    for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (sync2[i] == stable[i]) begin
                            cnt[i] <= '0;
                        end else if (cnt[i] == TERM) begin
                            stable[i] <= sync2[i];
                            cnt[i]    <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stable_d <= RESET_LEVEL;
        else          stable_d <= stable;
    end

    assign rise = stable & ~stable_d;
    assign fall = ~stable & stable_d;
    assign edge_hit = (EDGE_MODE == 0) ? rise :
                      (EDGE_MODE == 1) ? fall : (rise | fall);

    assign wr  = chipselect & ~write_n;
    assign clr = (wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0;

    // A new edge wins over a simultaneous write-1-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            if (wr && address == 3'd2) irq_mask <= writedata[WIDTH-1:0];
            edge_capture <= (edge_capture & ~clr) | edge_hit;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            3'd0:    rd_mux[WIDTH-1:0] = stable;
            3'd2:    rd_mux[WIDTH-1:0] = irq_mask;
            3'd3:    rd_mux[WIDTH-1:0] = edge_capture;
            default: rd_mux = '0;
        endcase
    end

    // Read data is registered every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_mux;
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_yt_system_pio_key.sv
// tb_yt_system_pio_key: directed table, corner sequences and randomized
// traffic checked against a behavioural model of the key PIO.
module tb_yt_system_pio_key;

    localparam int W   = 4;
    localparam int DEB = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [2:0]   address = '0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [31:0]  writedata = '0;
    logic [W-1:0] in_port = 4'hF;
    logic [31:0]  readdata;
    logic         irq;

    int errors = 0;
    int checks = 0;

    yt_system_pio_key #(
        .WIDTH(W), .DEBOUNCE_CNT(DEB), .EDGE_MODE(1), .RESET_LEVEL(4'hF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .in_port(in_port), .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // Behavioural model: levels seen after a 2-sample delay, accepted once
    // they have differed from the stable level for DEB consecutive samples.
    logic [W-1:0] hist [$];
    int           run [W];
    logic [W-1:0] m_stable, m_prev, m_mask, m_cap;
    logic [31:0]  m_rd;

    task automatic model_reset();
        hist.delete();
        hist.push_back(4'hF);
        hist.push_back(4'hF);
        for (int i = 0; i < W; i++) run[i] = 0;
        m_stable = 4'hF;
        m_prev   = 4'hF;
        m_mask   = '0;
        m_cap    = '0;
        m_rd     = '0;
    endtask

    task automatic model_edge(input logic [2:0] a, input logic cs,
                              input logic wn, input logic [31:0] wd,
                              input logic [W-1:0] inp);
        logic [W-1:0] syn;
        logic [W-1:0] falls;
        logic [W-1:0] clear;
        bit           w;
        syn = hist.pop_front();
        hist.push_back(inp);
        w = cs && !wn;
        case (a)
            3'd0:    m_rd = {28'd0, m_stable};
            3'd2:    m_rd = {28'd0, m_mask};
            3'd3:    m_rd = {28'd0, m_cap};
            default: m_rd = 32'd0;
        endcase
        falls = m_prev & ~m_stable;
        clear = (w && a == 3'd3) ? wd[W-1:0] : '0;
        m_cap = (m_cap & ~clear) | falls;
        if (w && a == 3'd2) m_mask = wd[W-1:0];
        m_prev = m_stable;
        for (int i = 0; i < W; i++) begin
            if (syn[i] == m_stable[i]) begin
                run[i] = 0;
            end else begin
                run[i]++;
                if (run[i] == DEB) begin
                    m_stable[i] = syn[i];
                    run[i] = 0;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, model at posedge, compare at negedge.
    task automatic step(input logic [2:0] a, input logic cs, input logic wn,
                        input logic [31:0] wd, input logic [W-1:0] inp);
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        in_port    = inp;
        @(posedge clk);
        model_edge(a, cs, wn, wd, inp);
        @(negedge clk);
        chk("model_rd", readdata, m_rd);
        chk("model_irq", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
    endtask

    task automatic rd(input logic [2:0] a, input logic [W-1:0] inp);
        step(a, 1'b1, 1'b1, 32'd0, inp);
    endtask

    task automatic wrt(input logic [2:0] a, input logic [31:0] wd,
                       input logic [W-1:0] inp);
        step(a, 1'b1, 1'b0, wd, inp);
    endtask

    typedef struct {
        logic [2:0]  a;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [W-1:0] keys;

        tbl[0]  = '{3'd2, 1'b1, 1'b0, 32'h5,        32'h0, 1'b0};
        tbl[1]  = '{3'd2, 1'b1, 1'b1, 32'h0,        32'h5, 1'b0};
        tbl[2]  = '{3'd6, 1'b1, 1'b0, 32'hFF,       32'h0, 1'b0};
        tbl[3]  = '{3'd0, 1'b1, 1'b1, 32'h0,        32'hF, 1'b0};
        tbl[4]  = '{3'd1, 1'b1, 1'b0, 32'h7,        32'h0, 1'b0};
        tbl[5]  = '{3'd2, 1'b0, 1'b0, 32'hA,        32'h5, 1'b0};
        tbl[6]  = '{3'd2, 1'b0, 1'b1, 32'h0,        32'h5, 1'b0};
        tbl[7]  = '{3'd2, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h5, 1'b0};
        tbl[8]  = '{3'd2, 1'b1, 1'b1, 32'h0,        32'hF, 1'b0};
        tbl[9]  = '{3'd3, 1'b1, 1'b1, 32'h0,        32'h0, 1'b0};
        tbl[10] = '{3'd2, 1'b1, 1'b0, 32'h0,        32'hF, 1'b0};
        tbl[11] = '{3'd7, 1'b1, 1'b1, 32'h0,        32'h0, 1'b0};

        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", {31'd0, irq}, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].a, tbl[i].cs, tbl[i].wn, tbl[i].wd, 4'hF);
            chk($sformatf("tbl%0d_rd", i), readdata, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_irq", i), {31'd0, irq},
                {31'd0, tbl[i].exp_irq});
        end

        // Falling edge: captured exactly 7 edges after the change
        for (int k = 1; k <= 8; k++) begin
            rd(3'd3, 4'hE);
            if (k == 7) chk("fall_not_early", readdata, 32'h0);
            if (k == 8) chk("fall_capture", readdata, 32'h1);
        end
        rd(3'd0, 4'hE);
        chk("fall_data", readdata, 32'hE);
        chk("masked_irq", {31'd0, irq}, 32'h0);

        // Interrupt masking
        wrt(3'd2, 32'h1, 4'hE);
        chk("irq_unmasked", {31'd0, irq}, 32'h1);
        wrt(3'd3, 32'h1, 4'hE);
        chk("irq_cleared", {31'd0, irq}, 32'h0);
        rd(3'd3, 4'hE);
        chk("cap_cleared", readdata, 32'h0);

        // Glitch rejection: 3-cycle low pulse on bit 0
        repeat (8) rd(3'd0, 4'hF);
        chk("release_no_capture", {31'd0, irq}, 32'h0);
        repeat (3) rd(3'd0, 4'hE);
        repeat (10) rd(3'd0, 4'hF);
        chk("glitch_data", readdata, 32'hF);
        rd(3'd3, 4'hF);
        chk("glitch_cap", readdata, 32'h0);

        // Set/clear collision on bit 0
        for (int k = 1; k <= 6; k++) rd(3'd3, 4'hE);
        wrt(3'd3, 32'h1, 4'hE);
        rd(3'd3, 4'hE);
        chk("collision_cap", readdata, 32'h1);
        chk("collision_irq", {31'd0, irq}, 32'h1);

        // Reset in the middle of a debounce count
        repeat (8) rd(3'd0, 4'hF);
        for (int k = 1; k <= 4; k++) rd(3'd0, 4'hE);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_readdata", readdata, 32'h0);
        chk("midrst_irq", {31'd0, irq}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        rd(3'd2, 4'hE);
        chk("midrst_mask", readdata, 32'h0);
        for (int k = 2; k <= 8; k++) begin
            rd(3'd3, 4'hE);
            if (k == 7) chk("midrst_no_early", readdata, 32'h0);
            if (k == 8) chk("midrst_recapture", readdata, 32'h1);
        end

        // Randomized traffic against the model
        keys = 4'hE;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 5) == 0) keys[b] = ~keys[b];
            step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0), $urandom, keys);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
